// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: Game Boy IF/IE/IME state and interrupt dispatch sequencer
module interrupt_ctrl #(
  parameter int NUM_IRQ = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               instr_boundary,
  input  logic               ei_exec,
  input  logic               di_exec,
  input  logic               reti_exec,
  input  logic [7:0]         reg_wr_data,
  input  logic               if_wr,
  input  logic               ie_wr,
  output logic [7:0]         if_rd_data,
  output logic [7:0]         ie_rd_data,
  output logic               ime,
  output logic               int_busy,
  output logic [2:0]         int_vector,
  output logic               stack_push_hi,
  output logic               stack_push_lo,
  output logic               pc_load_int,
  output logic               halt_wake
);
  typedef enum logic [2:0] {IDLE, ACK, WAIT, PUSH_HI, PUSH_LO, JUMP} state_t;
  state_t state;
  logic [NUM_IRQ-1:0] if_q, pending, if_clr;
  logic [7:0] ie_q;
  logic [2:0] sel;
  logic ei_pending, accept;
  assign pending = ie_q[NUM_IRQ-1:0] & if_q;
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pending[i]) sel = 3'(i);
  end
  assign accept = state == IDLE && instr_boundary && ime && |pending;
  assign if_clr = state == ACK ? NUM_IRQ'(1) << int_vector : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      if_q <= '0;
      ie_q <= '0;
      ime <= 1'b0;
      ei_pending <= 1'b0;
      int_vector <= '0;
    end else begin
      // same-cycle requests beat both CPU writes and the acknowledge clear
      if_q <= ((if_wr ? reg_wr_data[NUM_IRQ-1:0] : if_q) & ~if_clr) | irq_req;
      if (ie_wr) ie_q <= reg_wr_data;
      ime <= di_exec || accept ? 1'b0 : reti_exec || (ei_pending && instr_boundary) ? 1'b1 : ime;
      ei_pending <= di_exec || accept ? 1'b0 : ei_exec ? 1'b1 : instr_boundary ? 1'b0 : ei_pending;
      if (accept) int_vector <= sel;
      case (state)
        IDLE:    state <= accept ? ACK : IDLE;
        ACK:     state <= WAIT;
        WAIT:    state <= PUSH_HI;
        PUSH_HI: state <= PUSH_LO;
        PUSH_LO: state <= JUMP;
        default: state <= IDLE;
      endcase
    end
  end
  assign if_rd_data    = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign ie_rd_data    = ie_q;
  assign int_busy      = state != IDLE;
  assign stack_push_hi = state == PUSH_HI;
  assign stack_push_lo = state == PUSH_LO;
  assign pc_load_int   = state == JUMP;
  assign halt_wake     = |pending;
endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
Game Boy interrupt controller that owns the IF/IE/IME state and sequences the PC datapath through an interrupt dispatch. At an instruction boundary it arbitrates among five interrupt sources by fixed priority and drives the 3-bit vector index. It emits the stack push strobes for the return address, then the PC load strobe that jumps to 0x40 + 8*index. It also supplies the HALT wake-up condition and the EI/DI/RETI semantics of IME.

Parameters:
NUM_IRQ, 5, number of interrupt sources: 0 VBlank, 1 LCD STAT, 2 Timer, 3 Serial, 4 Joypad; index 0 has the highest priority.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
irq_req  input  5  per-source request pulses; each set bit sets the matching IF bit
instr_boundary  input  1  CPU is between instructions; the dispatch decision is taken here
ei_exec  input  1  EI instruction executed this cycle
di_exec  input  1  DI instruction executed this cycle
reti_exec  input  1  RETI instruction executed this cycle
reg_wr_data  input  8  CPU write data for IF/IE
if_wr  input  1  write reg_wr_data[4:0] to IF (0xFF0F)
ie_wr  input  1  write reg_wr_data to IE (0xFFFF)
if_rd_data  output  8  {3'b111, IF[4:0]}
ie_rd_data  output  8  IE[7:0]
ime  output  1  interrupt master enable
int_busy  output  1  dispatch in progress; the CPU stalls its own sequencing
int_vector  output  3  latched vector index for the PC interrupt-address mux
stack_push_hi  output  1  push PC[15:8] this cycle
stack_push_lo  output  1  push PC[7:0] this cycle
pc_load_int  output  1  select the interrupt address into the PC this cycle
halt_wake  output  1  |(IE[4:0] & IF[4:0]), independent of IME

Behaviour:
- Reset, taking priority over everything and abandoning any dispatch mid-sequence:
  - state = IDLE; IF = 0; IE = 0; ime = 0; ei_pending = 0; int_vector = 0.
  - All strobes and int_busy are 0, so if_rd_data = 0xE0 and ie_rd_data = 0x00.
- pending = IE[4:0] & IF[4:0]. sel = index of the lowest set bit of pending.
- IF next-value order:
  - base = if_wr ? reg_wr_data[4:0] : IF;
  - then the ACK-state clear of bit int_vector;
  - then OR irq_req. A request on the same cycle as a write or clear therefore wins.
- IE: 8-bit register loaded on ie_wr; all 8 bits are readable, and only bits [4:0] take part in pending.
- IME:
  - di_exec clears ime and ei_pending in the same cycle.
  - reti_exec sets ime in the next cycle.
  - ei_exec sets ei_pending. At the next instr_boundary after the EI cycle (not the same cycle), ime is set and ei_pending is cleared. The dispatch check at that boundary uses the old ime = 0, so exactly one more instruction executes.
  - Priority: di_exec beats ei/reti in the same cycle. Entering ACK clears ime and ei_pending.
- FSM: IDLE -> ACK -> WAIT -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE, one clock per state.
  - IDLE: if instr_boundary && ime && pending != 0, then latch int_vector = sel and go to ACK; otherwise stay.
  - ACK: clear IF[int_vector] and ime.
  - WAIT: idle cycle matching the CPU's internal M-cycle.
  - PUSH_HI: stack_push_hi = 1.
  - PUSH_LO: stack_push_lo = 1.
  - JUMP: pc_load_int = 1, then return to IDLE.
- Outputs are decoded from the registered state. int_busy = 1 in every non-IDLE state. A boundary at edge N gives ACK in cycle N+1 and pc_load_int in cycle N+5.
- int_vector holds its value until the next dispatch is accepted, even if pending changes during the sequence.
- The IDLE check is not re-evaluated during a dispatch. The next dispatch needs a fresh instr_boundary in IDLE with ime = 1.
- instr_boundary, ei/di/reti and register writes arriving while int_busy = 1 still update IF/IE/IME normally, but never start a new dispatch.
- halt_wake is combinational from the registers and ignores ime and state.

Test Plan:
1. Reset, then IE = 0x1F, ime set via reti_exec, irq_req = 0b00100 one cycle, then instr_boundary -> ACK next cycle; int_vector = 2; IF = 0; stack_push_hi at +3 cycles, stack_push_lo at +4, pc_load_int at +5; ime = 0.
2. IF = 0x1A, IE = 0x1F, ime = 1, boundary -> int_vector = 1 (lowest index wins); IF afterwards = 0x18; if_rd_data = 0xF8.
3. ime = 0, IE = 0x04, IF = 0x04 -> halt_wake = 1, no dispatch on boundaries. Set IE = 0x00 -> halt_wake = 0.
4. ei_exec at cycle T, pending nonzero, boundaries at T+1 and T+3 -> no dispatch at T+1 (ime rises after it); dispatch accepted at T+3. Repeat with di_exec at T+2 -> no dispatch.
5. if_wr with data 0x00 in the same cycle as irq_req = 0b00001 -> IF = 0x01. During ACK of vector 0, a new irq_req[0] -> IF[0] stays 1.
6. Reset asserted during PUSH_LO -> next cycle state IDLE, all strobes 0, IF = 0, IE = 0, ime = 0, int_busy = 0.
